mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single word-wide main-memory port between the instruction cache (read-only block refills) and the data cache (block reads and write-backs).
- Each grant is one locked burst of BURST_LEN consecutive words. The arbiter sequences beat addresses, returns read data or feeds write data, and signals completion.
- Sits between the two caches and the memory model. Round-robin between requesters, with an instruction-side abort for pipeline flushes.

Parameters:
- ADDR_W, 16, address width in words
- DATA_W, 16, word width
- BURST_LEN, 4, words per burst; power of two, at least 2
- BEAT_W, 2, log2(BURST_LEN)

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- i_req  input  1  icache refill request (level)
- i_addr  input  ADDR_W  icache miss address; low BEAT_W bits ignored
- i_abort  input  1  icache flush; cancels an icache burst
- i_rdata  output  DATA_W  icache read word
- i_rvalid  output  1  icache read word valid (1-cycle pulse)
- i_done  output  1  icache burst complete (1-cycle pulse)
- d_req  input  1  dcache request (level)
- d_we  input  1  dcache direction: 1 = write-back, 0 = refill
- d_addr  input  ADDR_W  dcache block address; low BEAT_W bits ignored
- d_wdata  input  DATA_W  write word for the beat shown on d_beat
- d_beat  output  BEAT_W  current beat index of the dcache burst
- d_rdata  output  DATA_W  dcache read word
- d_rvalid  output  1  dcache read word valid (1-cycle pulse)
- d_done  output  1  dcache burst complete (1-cycle pulse)
- m_read  output  1  memory read strobe
- m_write  output  1  memory write strobe
- m_addr  output  ADDR_W  memory word address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid with m_ready
- m_ready  input  1  memory finished the current word

Behaviour:
- Reset and clock: reset reset_n, synchronous, active-low; clock clk.
- Reset state:
  - all outputs 0, state IDLE, beat counter 0.
  - last_grant = I, so the dcache wins the first contention.
  - Reset mid-burst: next cycle all outputs are 0 and the state is IDLE; no done or rvalid is issued.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Samples requests each edge.
  - If only d_req is high, go to GNT_D. If only i_req is high and i_abort is low, go to GNT_I.
  - If both are high, grant the side not named by last_grant, then update last_grant.
  - i_abort high suppresses i_req that cycle.
  - On grant, latch base = addr[ADDR_W-1:BEAT_W], clear beat, and latch d_we for a dcache grant.
- Grant timing: the memory strobe rises the cycle after the request is sampled.
- GNT_I:
  - m_read = 1, m_write = 0, m_addr = {base, beat}.
  - On m_ready: the next cycle i_rdata = m_rdata (registered) with i_rvalid = 1, and beat increments.
  - On the m_ready of the last beat, the next cycle also pulses i_done, drops m_read and returns to IDLE.
- GNT_D:
  - If d_we = 0: m_read = 1 and behaviour is identical to GNT_I, using d_rdata, d_rvalid and d_done.
  - If d_we = 1:
    - m_write = 1 and m_wdata = d_wdata (combinational pass-through).
    - d_beat = beat; the requester presents word[d_beat].
    - On m_ready, beat increments.
    - On the last beat, d_done pulses the next cycle.
  - d_req and d_we are not re-sampled during the burst.
- Memory strobe: m_read/m_write stay high continuously across beats. If m_ready is held high, one word completes per cycle and a burst occupies BURST_LEN cycles of strobe.
- Idle gap: IDLE always lasts at least one cycle between bursts. done and the IDLE cycle coincide; no back-to-back grant on the same edge.
- Abort:
  - i_abort in GNT_I goes to IDLE next cycle with m_read = 0, beat = 0, and no further i_rvalid or i_done.
  - A word completing (m_ready) on the same cycle as i_abort is dropped (no i_rvalid).
  - i_abort in GNT_D has no effect.
- Mutual exclusion: m_read and m_write are never both high; i_* and d_* valid/done pulses are never simultaneous.
- Beat counter: wraps modulo BURST_LEN; only the terminal beat ends the burst.

Test Plan:
1. Reset, then i_req = 1, i_addr = 0x0013, memory with m_ready every 2nd cycle, data = address ^ 0xA000 -> m_addr 0x0010, 0x0011, 0x0012, 0x0013; i_rdata 0xA010..0xA013 with four i_rvalid pulses; i_done on the 4th; m_read low afterwards.
2. After reset, i_req and d_req (d_we = 0, d_addr = 0x0200) rise together, m_ready always 1 -> GNT_D first: m_addr 0x0200..0x0203, d_done, one IDLE cycle, then the icache burst. Repeating the simultaneous request grants I first.
3. d_req, d_we = 1, d_addr = 0x0105; the bench drives d_wdata = 0x1000 + d_beat -> m_write for 4 beats at 0x0104..0x0107 with m_wdata 0x1000..0x1003, one d_done pulse, and no d_rvalid.
4. Icache burst: assert i_abort the cycle after the 2nd i_rvalid while d_req is pending -> m_read low next cycle, no more i_rvalid, no i_done, and the dcache is granted after one IDLE cycle.
5. Reset_n low for one cycle during beat 2 of a dcache write -> next cycle all outputs are 0, state IDLE, no d_done; a subsequent simultaneous request grants D (last_grant reset to I).
6. i_abort high in GNT_D mid-burst -> the burst completes normally with all 4 beats and d_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one word-wide main-memory port between icache
// refills and dcache refills/write-backs. Each grant is a locked burst of
// BURST_LEN consecutive words. Contention is resolved round-robin, and the
// icache may abort its own burst on a pipeline flush.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [BEAT_W-1:0] d_beat,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_e;

  localparam int                BASE_W    = ADDR_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                dwe_q, dwe_d;
  // 1 when the dcache won the most recent contention
  logic                lg_is_d_q, lg_is_d_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                i_done_q, i_done_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                d_done_q, d_done_d;

  logic i_req_eff_s;
  logic last_beat_s;
  logic gnt_s;
  logic unused_addr_lsb_s;

  // A flush in the same cycle hides the icache request from arbitration
  assign i_req_eff_s = i_req & ~i_abort;
  assign last_beat_s = (beat_q == LAST_BEAT);
  assign gnt_s       = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);

  // Word offset within a block is supplied by the beat counter, not the requester
  assign unused_addr_lsb_s = ^{i_addr[BEAT_W-1:0], d_addr[BEAT_W-1:0]};

  // Memory-side strobes are decoded straight from registered state
  assign m_read   = (state_q == ST_GNT_I) || ((state_q == ST_GNT_D) && !dwe_q);
  assign m_write  = (state_q == ST_GNT_D) && dwe_q;
  assign m_addr   = gnt_s ? {base_q, beat_q} : {ADDR_W{1'b0}};
  assign m_wdata  = m_write ? d_wdata : {DATA_W{1'b0}};
  assign d_beat   = (state_q == ST_GNT_D) ? beat_q : {BEAT_W{1'b0}};

  assign i_rdata  = i_rdata_q;
  assign i_rvalid = i_rvalid_q;
  assign i_done   = i_done_q;
  assign d_rdata  = d_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_done   = d_done_q;

  // Next-state: arbitration in IDLE, beat sequencing and completion in grants
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    dwe_d      = dwe_q;
    lg_is_d_d  = lg_is_d_q;
    i_rdata_d  = i_rdata_q;
    i_rvalid_d = 1'b0;
    i_done_d   = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_rvalid_d = 1'b0;
    d_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_d = {BEAT_W{1'b0}};
        if (d_req && i_req_eff_s) begin
          // Contention: whoever did not win last time goes first
          lg_is_d_d = ~lg_is_d_q;
          if (lg_is_d_q) begin
            state_d = ST_GNT_I;
            base_d  = i_addr[ADDR_W-1:BEAT_W];
          end else begin
            state_d = ST_GNT_D;
            base_d  = d_addr[ADDR_W-1:BEAT_W];
            dwe_d   = d_we;
          end
        end else if (d_req) begin
          state_d = ST_GNT_D;
          base_d  = d_addr[ADDR_W-1:BEAT_W];
          dwe_d   = d_we;
        end else if (i_req_eff_s) begin
          state_d = ST_GNT_I;
          base_d  = i_addr[ADDR_W-1:BEAT_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_I: begin
        if (i_abort) begin
          // Flush wins over a word completing in the same cycle
          state_d = ST_IDLE;
          beat_d  = {BEAT_W{1'b0}};
        end else if (m_ready) begin
          i_rdata_d  = m_rdata;
          i_rvalid_d = 1'b1;
          beat_d     = beat_q + BEAT_W'(1);
          if (last_beat_s) begin
            i_done_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_GNT_I;
          end
        end else begin
          state_d = ST_GNT_I;
        end
      end
      ST_GNT_D: begin
        if (m_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (!dwe_q) begin
            d_rdata_d  = m_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            d_rvalid_d = 1'b0;
          end
          if (last_beat_s) begin
            d_done_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_GNT_D;
          end
        end else begin
          state_d = ST_GNT_D;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= {BEAT_W{1'b0}};
      base_q     <= {BASE_W{1'b0}};
      dwe_q      <= 1'b0;
      lg_is_d_q  <= 1'b0;
      i_rdata_q  <= {DATA_W{1'b0}};
      i_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_rdata_q  <= {DATA_W{1'b0}};
      d_rvalid_q <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      dwe_q      <= dwe_d;
      lg_is_d_q  <= lg_is_d_d;
      i_rdata_q  <= i_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      i_done_q   <= i_done_d;
      d_rdata_q  <= d_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_done_q   <= d_done_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: table of directed scenarios, randomized
// scenarios against a burst-level reference model, and hand-written
// sequences for grant timing, abort and mid-burst reset.
module tb_mem_port_arbiter;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_abort, i_rvalid, i_done;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_we, d_rvalid, d_done;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_beat;
  logic        m_read, m_write, m_ready;
  logic [15:0] m_addr, m_wdata, m_rdata;

  logic [15:0] wbase;
  int          rmode;
  int          cyc;

  always #5 clk = ~clk;

  // dcache write agent presents word[d_beat]; memory returns address ^ 0xA000
  assign d_wdata = wbase + {14'd0, d_beat};
  assign m_rdata = m_ready ? (m_addr ^ 16'hA000) : 16'h5A5A;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_beat(d_beat), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t       beat_q[$];
  logic [15:0] qi[$];
  logic [15:0] qd[$];
  int          ni_done, nd_done, viol;
  int          checks = 0;
  int          failures = 0;
  bit          lg_d;

  // Monitor: collects completed memory words, read returns and done pulses
  always @(negedge clk) begin
    if (reset_n && (m_read || m_write) && m_ready)
      beat_q.push_back({m_write, m_addr, m_write ? m_wdata : 16'h0000});
    if (i_rvalid) qi.push_back(i_rdata);
    if (d_rvalid) qd.push_back(d_rdata);
    if (i_done) ni_done++;
    if (d_done) nd_done++;
    if (m_read && m_write) viol++;
    if ((i_rvalid || i_done) && (d_rvalid || d_done)) viol++;
    if ((i_done || d_done) && (m_read || m_write)) viol++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2 == 1);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (i_done) i_req = 1'b0;
    if (d_done) d_req = 1'b0;
  endtask

  task automatic clear_mon();
    beat_q.delete();
    qi.delete();
    qd.delete();
    ni_done = 0;
    nd_done = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    i_abort = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    lg_d    = 1'b0;
  endtask

  // Reference arbitration: on contention the side that did not win the
  // previous contention goes first; a lone requester simply goes.
  function automatic bit pick_d(input bit ir, input bit dr);
    bit f;
    if (ir && dr) begin
      f    = !lg_d;
      lg_d = f;
    end else begin
      f = dr;
    end
    return f;
  endfunction

  // Expected traffic: each requester gets BL words from its block start
  task automatic check_scn(input string tag, input bit ir, input logic [15:0] ia,
                           input bit dr, input bit dw, input logic [15:0] da,
                           input logic [15:0] wb, input bit first_d);
    beat_t       exp_b[$];
    logic [15:0] exp_i[$];
    logic [15:0] exp_d[$];
    logic [15:0] a;
    bit          side_d, wr;
    for (int s = 0; s < 2; s++) begin
      side_d = (s == 0) ? first_d : !first_d;
      if (side_d ? dr : ir) begin
        for (int k = 0; k < BL; k++) begin
          a  = 16'(((side_d ? da : ia) / BL) * BL + k);
          wr = side_d && dw;
          exp_b.push_back({wr, a, wr ? 16'(wb + k) : 16'h0000});
          if (!wr && side_d) exp_d.push_back(a ^ 16'hA000);
          if (!wr && !side_d) exp_i.push_back(a ^ 16'hA000);
        end
      end
    end
    chk({tag, " beat count"}, beat_q.size(), exp_b.size());
    foreach (exp_b[k]) if (k < beat_q.size()) chk({tag, " beat"}, beat_q[k], exp_b[k]);
    chk({tag, " i_rvalid count"}, qi.size(), exp_i.size());
    foreach (exp_i[k]) if (k < qi.size()) chk({tag, " i_rdata"}, qi[k], exp_i[k]);
    chk({tag, " d_rvalid count"}, qd.size(), exp_d.size());
    foreach (exp_d[k]) if (k < qd.size()) chk({tag, " d_rdata"}, qd[k], exp_d[k]);
    chk({tag, " i_done count"}, ni_done, ir);
    chk({tag, " d_done count"}, nd_done, dr);
  endtask

  task automatic run_scn(input string tag, input bit ir, input logic [15:0] ia,
                         input bit dr, input bit dw, input logic [15:0] da,
                         input int mode, input logic [15:0] wb);
    bit fd;
    int n;
    clear_mon();
    step();
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    rmode = mode; wbase = wb;
    fd = pick_d(ir, dr);
    n = 0;
    while ((i_req || d_req) && n < 400) begin
      step();
      n++;
    end
    chk({tag, " completes in budget"}, n < 400, 1'b1);
    step();
    step();
    check_scn(tag, ir, ia, dr, dw, da, wb, fd);
  endtask

  typedef struct {
    bit          ir;
    logic [15:0] ia;
    bit          dr;
    bit          dw;
    logic [15:0] da;
    int          mode;
    logic [15:0] exp_first;
    int          exp_beats;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    vt[0] = '{1'b1, 16'h0013, 1'b0, 1'b0, 16'h0000, 1, 16'h0010, 4};
    vt[1] = '{1'b1, 16'h0013, 1'b1, 1'b0, 16'h0200, 0, 16'h0200, 8};
    vt[2] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0300, 0, 16'h0040, 8};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0105, 0, 16'h0104, 4};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 2, 16'hFFFC, 4};
    vt[5] = '{1'b1, 16'h1232, 1'b1, 1'b1, 16'h0007, 2, 16'h0004, 8};

    i_addr = 16'h0000; d_addr = 16'h0000; d_we = 1'b0;
    wbase = 16'h1000; rmode = 0; m_ready = 1'b0; cyc = 0;
    ni_done = 0; nd_done = 0; viol = 0;
    i_req = 1'b0; d_req = 1'b0; i_abort = 1'b0; reset_n = 1'b0;

    // Reset state and grant timing
    do_reset();
    chk("reset outputs", {i_rdata, i_rvalid, i_done, d_beat, d_rdata, d_rvalid, d_done,
                          m_read, m_write, m_addr, m_wdata}, 128'h0);
    clear_mon();
    rmode = 0;
    step();
    i_req = 1'b1; i_addr = 16'h0022;
    chk("strobe low before sample", m_read, 1'b0);
    step();
    chk("strobe high after sample", {m_read, m_write, m_addr}, {1'b1, 1'b0, 16'h0020});
    n = 0;
    while (i_req && n < 50) begin step(); n++; end
    step();
    chk("timing burst words", qi.size(), 4);

    // Table-driven scenarios
    do_reset();
    foreach (vt[v]) begin
      run_scn("table", vt[v].ir, vt[v].ia, vt[v].dr, vt[v].dw, vt[v].da, vt[v].mode, 16'h1000);
      chk("table first addr", (beat_q.size() > 0) ? beat_q[0].addr : 16'hDEAD, vt[v].exp_first);
      chk("table total beats", beat_q.size(), vt[v].exp_beats);
    end

    // Icache abort after the 2nd read word while the dcache waits
    clear_mon();
    rmode = 0;
    step();
    i_req = 1'b1; i_addr = 16'h0080;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    n = 0;
    while (qi.size() < 2 && n < 50) begin step(); n++; end
    i_abort = 1'b1; i_req = 1'b0;
    step();
    i_abort = 1'b0;
    chk("abort drops strobe", {m_read, m_write}, 2'b00);
    chk("abort drops word", {i_rvalid, i_done}, 2'b00);
    step();
    chk("dcache granted after abort", {m_read, m_addr}, {1'b1, 16'h0400});
    n = 0;
    while (d_req && n < 50) begin step(); n++; end
    step(); step();
    chk("abort i_rvalid count", qi.size(), 3);
    chk("abort last i_rdata", (qi.size() > 2) ? qi[2] : 16'hDEAD, 16'hA082);
    chk("abort no i_done", ni_done, 0);
    chk("abort d_done", nd_done, 1);

    // Reset during beat 2 of a dcache write
    clear_mon();
    rmode = 0; wbase = 16'h1000;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0105;
    n = 0;
    while (d_beat != 2'd2 && n < 50) begin step(); n++; end
    chk("reached beat 2", d_beat, 2'd2);
    reset_n = 1'b0; d_req = 1'b0;
    step();
    chk("mid-burst reset outputs", {i_rdata, i_rvalid, i_done, d_beat, d_rdata, d_rvalid, d_done,
                                    m_read, m_write, m_addr, m_wdata}, 128'h0);
    reset_n = 1'b1; lg_d = 1'b0;
    step(); step();
    chk("no d_done after reset", nd_done, 0);
    run_scn("post-reset", 1'b1, 16'h0050, 1'b1, 1'b0, 16'h0700, 0, 16'h1000);
    chk("post-reset D first", (beat_q.size() > 0) ? beat_q[0].addr : 16'hDEAD, 16'h0700);

    // i_abort during a dcache burst has no effect
    clear_mon();
    rmode = 1;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600;
    n = 0;
    while (qd.size() < 2 && n < 50) begin step(); n++; end
    i_abort = 1'b1;
    n = 0;
    while (d_req && n < 50) begin step(); n++; end
    i_abort = 1'b0;
    step(); step();
    chk("D abort-immune words", qd.size(), 4);
    chk("D abort-immune last word", (qd.size() > 3) ? qd[3] : 16'hDEAD, 16'hA603);
    chk("D abort-immune done", nd_done, 1);

    // Randomized scenarios against the reference model
    for (int r = 0; r < 16; r++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      run_scn("random", ir, 16'($urandom), dr, 1'($urandom), 16'($urandom),
              int'($urandom_range(0, 2)), 16'($urandom));
    end

    chk("protocol invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
